// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode constants.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx_gen_if.sv
// Word handshake, serial line and frame status of the UART transmitter.
interface uart_tx_gen_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_in;
   logic                 valid_in;
   logic                 ready_out;
   logic                 data_out;
   logic                 busy;
   logic                 done;

   modport master (
      output data_in, valid_in,
      input  ready_out, data_out, busy, done
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, data_out, busy, done
   );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_end marks the last clock of each serial bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_end
);
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt;

   assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   // Wraps to 0 at every bit boundary; held at 0 while restart is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: one-entry holding register feeding a serial framing FSM.
// Parity support is compiled in only when UART_TX_GEN_PARITY_EN is defined.
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 2,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_MODE  = PAR_NONE
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_gen_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   uart_state_t          state;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_full;
   logic [DATA_BITS-1:0] shift;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic                 line;
   logic                 busy;
   logic                 frame_end;
   logic                 done;
   logic                 bit_end;
   logic                 restart_c;
   logic                 last_stop_c;
   logic                 load_c;
`ifdef UART_TX_GEN_PARITY_EN
   localparam bit PAR_ON = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
   logic par_bit;
`endif

   assign bus.ready_out = ~hold_full & ~rst;
   assign bus.data_out  = line;
   assign bus.busy      = busy;
   assign bus.done      = done;

   assign restart_c   = (state == S_IDLE);
   assign last_stop_c = (stop_idx == 1'(STOP_BITS - 1));
   assign load_c      = hold_full &&
                        ((state == S_IDLE) ||
                         ((state == S_STOP) && bit_end && last_stop_c));

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (restart_c),
      .bit_end (bit_end)
   );

   // Line, busy and done are registered from the current state, so they trail the FSM by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         hold_data <= '0;
         hold_full <= 1'b0;
         shift     <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         line      <= 1'b1;
         busy      <= 1'b0;
         frame_end <= 1'b0;
         done      <= 1'b0;
`ifdef UART_TX_GEN_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         frame_end <= 1'b0;
         done      <= frame_end;

         if (bus.valid_in && !hold_full) begin
            hold_data <= bus.data_in;
            hold_full <= 1'b1;
         end

         if (load_c) begin
            shift     <= hold_data;
            hold_full <= 1'b0;
`ifdef UART_TX_GEN_PARITY_EN
            par_bit   <= (^hold_data) ^ (PARITY_MODE == PAR_ODD);
`endif
         end

         case (state)
            S_IDLE: begin
               line <= 1'b1;
               busy <= 1'b0;
               if (hold_full) state <= S_START;
            end
            S_START: begin
               line <= 1'b0;
               busy <= 1'b1;
               if (bit_end) state <= S_DATA;
            end
            S_DATA: begin
               line <= shift[0];
               busy <= 1'b1;
               if (bit_end) begin
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + IDX_W'(1);
                  if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                     bit_idx <= '0;
`ifdef UART_TX_GEN_PARITY_EN
                     state   <= PAR_ON ? S_PARITY : S_STOP;
`else
                     state   <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_GEN_PARITY_EN
            S_PARITY: begin
               line <= par_bit;
               busy <= 1'b1;
               if (bit_end) state <= S_STOP;
            end
`endif
            S_STOP: begin
               line <= 1'b1;
               busy <= 1'b1;
               if (bit_end) begin
                  if (last_stop_c) begin
                     stop_idx  <= 1'b0;
                     frame_end <= 1'b1;
                     state     <= hold_full ? S_START : S_IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               line  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: four configurations sharing one stimulus feeder.
module tb_uart_tx_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          acc_armed = 1'b0;
   int          sel = 0;
   logic        v = 1'b0;
   logic [7:0]  d = 8'h00;
   bit          rdy_s = 1'b0;
   logic [7:0]  q[$];
   logic        line, bsy, dn, rdy;

   uart_tx_gen_if #(.DATA_BITS(8)) if_a ();
   uart_tx_gen_if #(.DATA_BITS(8)) if_b ();
   uart_tx_gen_if #(.DATA_BITS(8)) if_e ();
   uart_tx_gen_if #(.DATA_BITS(8)) if_o ();

   assign if_a.valid_in = v && (sel == 0);
   assign if_b.valid_in = v && (sel == 1);
   assign if_e.valid_in = v && (sel == 2);
   assign if_o.valid_in = v && (sel == 3);
   assign if_a.data_in  = d;
   assign if_b.data_in  = d;
   assign if_e.data_in  = d;
   assign if_o.data_in  = d;

   uart_tx_gen #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(0))
      u_a (.clk(clk), .rst(rst), .bus(if_a));
   uart_tx_gen #(.DATA_BITS(8), .CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_MODE(0))
      u_b (.clk(clk), .rst(rst), .bus(if_b));
   uart_tx_gen #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(1))
      u_e (.clk(clk), .rst(rst), .bus(if_e));
   uart_tx_gen #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_MODE(2))
      u_o (.clk(clk), .rst(rst), .bus(if_o));

   always_comb begin
      case (sel)
         1:       {line, bsy, dn, rdy} = {if_b.data_out, if_b.busy, if_b.done, if_b.ready_out};
         2:       {line, bsy, dn, rdy} = {if_e.data_out, if_e.busy, if_e.done, if_e.ready_out};
         3:       {line, bsy, dn, rdy} = {if_o.data_out, if_o.busy, if_o.done, if_o.ready_out};
         default: {line, bsy, dn, rdy} = {if_a.data_out, if_a.busy, if_a.done, if_a.ready_out};
      endcase
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Offers queued words; a word counts as taken if valid and ready were both high over the last edge.
   initial begin : feeder
      forever begin
         @(negedge clk);
         if (v && rdy_s) begin
            void'(q.pop_front());
            if (!acc_armed) begin
               acc_armed = 1'b1;
               acc_cyc   = cyc;
            end
         end
         if (q.size() > 0) begin
            v = 1'b1;
            d = q[0];
         end else begin
            v = 1'b0;
         end
         rdy_s = rdy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // frm holds the expected line bits, first bit on the line at index 0.
   task automatic frame_chk(input string tag, input logic [11:0] frm, input int nb,
                            input int cpb, input bit chk_lat, input bit next_b2b);
      int n;
      n = 0;
      while (line !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/start"}, 32'(line), 32'd0);
      if (chk_lat) chk({tag, "/latency"}, 32'(cyc - acc_cyc), 32'd2);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < cpb; c++) begin
            chk($sformatf("%s/bit%0d.%0d", tag, b, c), 32'(line), 32'(frm[b]));
            chk($sformatf("%s/busy%0d.%0d", tag, b, c), 32'(bsy), 32'd1);
            if (b != 0 || c != 0)
               chk($sformatf("%s/nodone%0d.%0d", tag, b, c), 32'(dn), 32'd0);
            @(negedge clk);
         end
      end
      chk({tag, "/done"}, 32'(dn), 32'd1);
      if (next_b2b) begin
         chk({tag, "/b2b_line"}, 32'(line), 32'd0);
         chk({tag, "/b2b_busy"}, 32'(bsy), 32'd1);
      end else begin
         chk({tag, "/idle_line"}, 32'(line), 32'd1);
         chk({tag, "/idle_busy"}, 32'(bsy), 32'd0);
         @(negedge clk);
         chk({tag, "/done_once"}, 32'(dn), 32'd0);
      end
   endtask

   task automatic push_words(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input int cnt);
      @(negedge clk);
      #1;
      acc_armed = 1'b0;
      q.push_back(w0);
      if (cnt > 1) q.push_back(w1);
      if (cnt > 2) q.push_back(w2);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $fatal(1, "simulation stalled");
   end

   initial begin : stim
      bit seen_low, seen_busy, seen_done;
      int n;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst/line", 32'(line), 32'd1);
      chk("rst/busy", 32'(bsy), 32'd0);
      chk("rst/done", 32'(dn), 32'd0);
      chk("rst/ready", 32'(rdy), 32'd0);
      sel = 1;
      #1;
      chk("rst/ready_b", 32'(rdy), 32'd0);
      sel = 0;
      #1;
      rst = 1'b0;
      #1;
      chk("rst/ready_release", 32'(rdy), 32'd1);

      // Single 0xA5 frame, 4 clocks per bit
      push_words(8'hA5, 8'h00, 8'h00, 1);
      frame_chk("a5", 12'h34A, 10, 4, 1'b1, 1'b0);

      // Parity frames (parity bit present only when compiled in)
      sel = 2;
      push_words(8'hA5, 8'h00, 8'h00, 1);
`ifdef UART_TX_GEN_PARITY_EN
      frame_chk("even", 12'h54A, 11, 4, 1'b1, 1'b0);
`else
      frame_chk("even", 12'h34A, 10, 4, 1'b1, 1'b0);
`endif
      sel = 3;
      push_words(8'hA5, 8'h00, 8'h00, 1);
`ifdef UART_TX_GEN_PARITY_EN
      frame_chk("odd", 12'h74A, 11, 4, 1'b1, 1'b0);
`else
      frame_chk("odd", 12'h34A, 10, 4, 1'b1, 1'b0);
`endif

      // Two stop bits, back-to-back frames
      sel = 1;
      push_words(8'h96, 8'h3C, 8'h00, 2);
      frame_chk("stop2_0", 12'h72C, 11, 2, 1'b1, 1'b1);
      frame_chk("stop2_1", 12'h678, 11, 2, 1'b0, 1'b0);

      // Back-to-back with a third word stalled against a full holding register
      sel = 0;
      push_words(8'h00, 8'hFF, 8'h5A, 3);
      fork
         begin
            frame_chk("b2b_00", 12'h200, 10, 4, 1'b1, 1'b1);
            frame_chk("b2b_ff", 12'h3FE, 10, 4, 1'b0, 1'b1);
            frame_chk("b2b_5a", 12'h2B4, 10, 4, 1'b0, 1'b0);
         end
         begin
            repeat (12) @(negedge clk);
            #1;
            chk("stall/ready", 32'(rdy), 32'd0);
            chk("stall/pending", 32'(q.size()), 32'd1);
         end
      join

      // Reset during data bit 3, with a second word held
      push_words(8'hC3, 8'h81, 8'h00, 2);
      n = 0;
      while (line !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("abort/start", 32'(line), 32'd0);
      repeat (17) @(negedge clk);
      chk("abort/pre_line", 32'(line), 32'd0);
      chk("abort/pre_busy", 32'(bsy), 32'd1);
      chk("abort/held", 32'(q.size()), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("abort/line", 32'(line), 32'd1);
      chk("abort/busy", 32'(bsy), 32'd0);
      chk("abort/done", 32'(dn), 32'd0);
      chk("abort/ready", 32'(rdy), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort/ready_release", 32'(rdy), 32'd1);
      seen_low  = 1'b0;
      seen_busy = 1'b0;
      seen_done = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (line !== 1'b1) seen_low = 1'b1;
         if (bsy !== 1'b0) seen_busy = 1'b1;
         if (dn !== 1'b0) seen_done = 1'b1;
      end
      chk("abort/quiet_line", 32'(seen_low), 32'd0);
      chk("abort/quiet_busy", 32'(seen_busy), 32'd0);
      chk("abort/quiet_done", 32'(seen_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
